// File: rtl/imem_loader.sv
// Program loader and run controller: packs a big-endian byte stream into 32-bit
// instruction-memory writes, then sequences core reset / run / halt.
module imem_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned RST_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic                run_req,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                hlt,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                core_rst,
  output logic                core_run,
  output logic [ADDR_W:0]     prog_len,
  output logic                err_ovf,
  output logic [2:0]          state_o
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam int unsigned CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CRST   = 3'd2,
    S_RUN    = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      bcnt;
  logic [31:0]     asm_q;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   rcnt;

  logic [31:0]     word_c;
  logic            accept_c;
  logic            done_c;
  logic            room_c;
  logic [PW-1:0]   wptr_nxt_c;

  // Current byte dropped into its big-endian lane; unfilled low lanes stay zero.
  always_comb begin
    word_c                          = asm_q;
    word_c[{~bcnt, 3'b000} +: 8]    = in_data;
    accept_c                        = in_valid & in_ready & (state == S_LOAD);
    done_c                          = accept_c & ((bcnt == 2'd3) | in_last);
    room_c                          = (wptr != PW'(DEPTH));
    wptr_nxt_c                      = wptr + PW'(done_c & room_c);
  end

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b0;
      core_run   <= 1'b0;
      prog_len   <= '0;
      err_ovf    <= 1'b0;
      bcnt       <= '0;
      asm_q      <= '0;
      wptr       <= '0;
      rcnt       <= '0;
    end else begin
      imem_we <= 1'b0;
      // A load request pre-empts whatever is in progress.
      if (load_req) begin
        state    <= S_LOAD;
        in_ready <= 1'b1;
        wptr     <= '0;
        bcnt     <= '0;
        asm_q    <= '0;
        err_ovf  <= 1'b0;
        core_rst <= 1'b0;
        core_run <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run_req && (prog_len != '0)) begin
              state    <= S_CRST;
              core_rst <= 1'b1;
              rcnt     <= '0;
            end
          end
          S_LOAD: begin
            if (accept_c) begin
              bcnt  <= bcnt + 2'd1;
              asm_q <= word_c;
              if (done_c) begin
                bcnt  <= '0;
                asm_q <= '0;
                wptr  <= wptr_nxt_c;
                if (room_c) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ADDR_W'(wptr);
                  imem_wdata <= word_c;
                end else begin
                  err_ovf <= 1'b1;
                end
              end
              if (in_last) begin
                prog_len <= wptr_nxt_c;
                state    <= S_IDLE;
                in_ready <= 1'b0;
              end
            end
          end
          S_CRST: begin
            if (rcnt == CW'(RST_CYC - 1)) begin
              state    <= S_RUN;
              core_rst <= 1'b0;
              core_run <= 1'b1;
            end else begin
              rcnt <= rcnt + CW'(1);
            end
          end
          S_RUN: begin
            if (hlt) begin
              state    <= S_HALTED;
              core_run <= 1'b0;
            end
          end
          S_HALTED: begin
            if (run_req) begin
              state    <= S_CRST;
              core_rst <= 1'b1;
              rcnt     <= '0;
            end
          end
          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            core_rst <= 1'b0;
            core_run <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and popped by a write monitor; control sequencing is checked inline per scenario.
module tb_imem_loader;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned RST_CYC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_req = 1'b0;
  logic              run_req = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              hlt = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              core_run;
  logic [ADDR_W:0]   prog_len;
  logic              err_ovf;
  logic [2:0]        state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] m_word;
  int          m_nb;
  int          m_wptr;
  bit          m_ovf;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .hlt(hlt), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_run(core_run), .prog_len(prog_len),
    .err_ovf(err_ovf), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h exp=none", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_word = '0;
    m_nb   = 0;
    m_wptr = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (in_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait got=%b exp=1", in_ready);
    end
    m_word[31 - 8*m_nb -: 8] = b;
    m_nb++;
    if (m_nb == 4 || last) begin
      if (m_wptr < int'(DEPTH)) begin
        exp_q.push_back({ADDR_W'(m_wptr), m_word});
        m_wptr++;
      end else begin
        m_ovf = 1'b1;
      end
      m_word = '0;
      m_nb   = 0;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({state_o, in_ready, imem_we, core_rst, core_run, err_ovf} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got st=%0d rdy=%b we=%b crst=%b crun=%b ovf=%b exp all 0",
               state_o, in_ready, imem_we, core_rst, core_run, err_ovf);
    end
    checks++;
    if (prog_len !== '0) begin
      errors++;
      $display("FAIL reset_prog_len got=%0d exp=0", prog_len);
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0d data=%h exp 0/0", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_load_basic();
    logic [7:0] p [5];
    p = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    pulse_load();
    checks++;
    if (state_o !== 3'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_enter got st=%0d rdy=%b exp st=1 rdy=1", state_o, in_ready);
    end
    for (int i = 0; i < 5; i++) send_byte(p[i], i == 4);
    checks++;
    if (state_o !== 3'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_exit got st=%0d rdy=%b exp st=0 rdy=0", state_o, in_ready);
    end
    tick();
    checks++;
    if (prog_len !== 5'd2) begin
      errors++;
      $display("FAIL load_prog_len got=%0d exp=2", prog_len);
    end
    checks++;
    if (imem_wdata !== 32'h9A000000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_last_word got data=%h pending=%0d exp data=9a000000 pending=0",
               imem_wdata, exp_q.size());
    end
  endtask

  task automatic test_run(input logic [ADDR_W:0] exp_len);
    int rc;
    rc = 0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++;
    if (state_o !== 3'd2 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL run_crst got st=%0d crun=%b exp st=2 crun=0", state_o, core_run);
    end
    while (core_rst === 1'b1 && rc < 10) begin
      rc++;
      tick();
    end
    checks++;
    if (rc != int'(RST_CYC)) begin
      errors++;
      $display("FAIL run_rst_cycles got=%0d exp=%0d", rc, RST_CYC);
    end
    checks++;
    if (state_o !== 3'd3 || core_run !== 1'b1) begin
      errors++;
      $display("FAIL run_enter got st=%0d crun=%b exp st=3 crun=1", state_o, core_run);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd3 || core_rst !== 1'b0 || core_run !== 1'b1) begin
      errors++;
      $display("FAIL run_ignore_req got st=%0d crst=%b crun=%b exp st=3 crst=0 crun=1",
               state_o, core_rst, core_run);
    end
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    checks++;
    if (state_o !== 3'd4 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL run_halt got st=%0d crun=%b exp st=4 crun=0", state_o, core_run);
    end
    checks++;
    if (prog_len !== exp_len || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_prog_len got=%0d pending=%0d exp=%0d pending=0",
               prog_len, exp_q.size(), exp_len);
    end
  endtask

  task automatic test_overflow();
    pulse_load();
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7 + 1), i == 19);
    tick();
    checks++;
    if (err_ovf !== m_ovf || prog_len !== 5'd4 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL ovf_flag got ovf=%b len=%0d st=%0d exp ovf=1 len=4 st=0",
               err_ovf, prog_len, state_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_writes got pending=%0d exp=0", exp_q.size());
    end
    pulse_load();
    checks++;
    if (err_ovf !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b st=%0d exp ovf=0 st=1", err_ovf, state_o);
    end
    send_byte(8'hAB, 1'b1);
    tick();
    checks++;
    if (prog_len !== 5'd1 || imem_wdata !== 32'hAB000000) begin
      errors++;
      $display("FAIL one_byte_prog got len=%0d data=%h exp len=1 data=ab000000",
               prog_len, imem_wdata);
    end
  endtask

  task automatic test_same_cycle();
    test_run(5'd1);
    load_req = 1'b1;
    run_req  = 1'b1;
    tick();
    load_req = 1'b0;
    run_req  = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (state_o !== 3'd1 || core_rst !== 1'b0 || core_run !== 1'b0) begin
        errors++;
        $display("FAIL same_cycle got st=%0d crst=%b crun=%b exp st=1 crst=0 crun=0",
                 state_o, core_rst, core_run);
      end
      tick();
    end
  endtask

  task automatic test_rst_midload();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    checks++;
    if (state_o !== 3'd0 || prog_len !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_midload got st=%0d len=%0d rdy=%b exp st=0 len=0 rdy=0",
               state_o, prog_len, in_ready);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0 || core_rst !== 1'b0 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL idle_run_ignored got st=%0d crst=%b crun=%b exp st=0 crst=0 crun=0",
               state_o, core_rst, core_run);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_basic();
    test_run(5'd2);
    test_run(5'd2);
    test_overflow();
    test_same_cycle();
    test_rst_midload();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
